spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
Synthesizable SPI-NOR flash responder (SPI mode 0, single-bit I/O) that answers the command stream the flash SPI master issues: READ, PAGE PROGRAM, WREN, WRDI and RDSR. It is backed by an internal byte array. It is placed on the flash bus in place of the external device, for board bring-up without flash and for closed-loop simulation of the flash-mapped memory path. All SPI pins are oversampled on the single system clock.

Parameters:
ADDR_BITS, 10, width of the internal byte array index (2^ADDR_BITS bytes); upper bits of the 24-bit address are ignored.
PAGE_BITS, 8, program page size = 2^PAGE_BITS bytes; program addresses wrap inside the page.
PROG_CYCLES, 64, clk cycles WIP stays set after a program commit.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sck  input  1  SPI clock from master (idle low)
cs  input  1  chip select, active low
mosi  input  1  serial data in
miso  output  1  serial data out
wel  output  1  write-enable latch
wip  output  1  write in progress
state_out  output  4  current FSM state, for debug

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: miso=0, wel=0, wip=0, state IDLE, WIP counter=0. The array is not cleared by reset; its power-up content is 0xFF for all bytes.
- Input conditioning: sck, cs and mosi pass through 2-FF synchronizers; sck edges are detected on the synchronized value.
- SCK timing requirement: high and low phases each >=4 clk.
- mosi is sampled on the detected sck rise; miso is updated on the detected sck fall.
- FSM states: IDLE, OPCODE, ADDR, READ, PROG, RDSR, IGNORE.
- cs deassert (synced cs=1) in any state: go to IDLE, clear the bit counter, miso=0. Then run the commit actions below in the same cycle.
- IDLE -> OPCODE on synced cs falling.
- In OPCODE, once 8 bits are received (MSB first):
  - 0x03 -> ADDR (read).
  - 0x02 with wel=1 and wip=0 -> ADDR (program).
  - 0x02 with wel=0 -> IGNORE.
  - 0x06 / 0x04 -> IGNORE, with the pending-WREN or pending-WRDI flag set.
  - 0x05 -> RDSR.
  - Anything else -> IGNORE.
  - While wip=1, only 0x05 is honoured; all other opcodes -> IGNORE.
- ADDR: receive 24 bits MSB first and keep the low ADDR_BITS. On the 24th rise, issue an array read (1 clk latency) to prefetch byte[addr].
- READ:
  - On each sck fall, shift out the next bit MSB first. The first fall after the last address bit drives bit7 of the prefetched byte.
  - When bit0 of a byte is driven, increment addr (wrapping modulo 2^ADDR_BITS) and prefetch the next byte.
  - Reads continue indefinitely until cs rises.
- PROG:
  - Each complete received byte D performs array[addr] <= array[addr] & D (NOR semantics: bits only go 1->0). This is a 2-cycle read-modify-write.
  - After the write, increment the low PAGE_BITS of addr, wrapping within the page.
  - A partial trailing byte is discarded.
  - Set the prog_done flag if at least one byte was written.
- RDSR: on every fall, shift out {6'b0, wel, wip}, repeated per byte until cs rises.
- IGNORE: miso=0; all input is discarded until cs rises.
- Commit actions on cs rise:
  - pending WREN and exactly 8 bits received -> wel=1.
  - pending WRDI with exactly 8 bits -> wel=0.
  - prog_done -> wel=0, wip=1, load counter=PROG_CYCLES.
- WIP timing: the counter decrements every clk while wip=1; wip clears on the cycle the counter reaches 0.
- Reset mid-transfer: all state is reset immediately. An in-flight RMW is abandoned; a byte already written stays written. A new transfer requires cs high then low.
- Simultaneous sck edge and cs rise: cs rise wins; the edge is ignored.

Decomposition:
- Shared package flash_cmd_pkg holds:
  - opcode constants OP_READ=8'h03, OP_PP=8'h02, OP_WREN=8'h06, OP_WRDI=8'h04, OP_RDSR=8'h05;
  - the FSM state encoding, which state_out exposes.
- Sub-module spi_pin_sync: 2-FF synchronizer plus rise/fall edge detect for sck, cs and mosi. The same sub-module is reusable by the slave interfaces.

Test Plan:
- After reset, RDSR (0x05) -> miso returns 0x00; wel=0, wip=0.
- READ 0x03 at 0x000010 for 3 bytes on a fresh device -> 0xFF,0xFF,0xFF.
- PP 0x02 at 0x000010 without WREN, data 0xA5 -> ignored; a following READ returns 0xFF; wel stays 0.
- WREN; then PP at 0x0000FE with data 0x11,0x22,0x33:
  - On cs rise: wel=0, wip=1 for 64 clk.
  - RDSR during that window returns 0x01.
  - READ afterwards returns 0x11@0xFE, 0x22@0xFF, 0x33@0x00 (page wrap).
- WREN, PP 0xF0 to a byte holding 0x3C -> READ returns 0x30 (AND semantics).
- READ starting at 0x0003FF for 2 bytes -> second byte comes from 0x000; address 0x4003FF aliases 0x3FF.
- Assert rst mid-READ while cs=0:
  - miso=0, state_out=IDLE.
  - Further sck edges are ignored until cs toggles.

Source files
------------

// File: rtl/flash_cmd_pkg.sv
// Shared definitions for the SPI-NOR flash responder and its master-side peers.
//   - opcode constants for the supported command set
//   - FSM state encoding (exposed on the responder's state_out debug port)
package flash_cmd_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_OPCODE = 4'd1,
      ST_ADDR   = 4'd2,
      ST_READ   = 4'd3,
      ST_PROG   = 4'd4,
      ST_RDSR   = 4'd5,
      ST_IGNORE = 4'd6
   } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer and edge detector for the SPI pins (sck, cs, mosi).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sck, cs, mosi     asynchronous SPI pins
//   cs_s, mosi_s      synchronized chip select / data
//   sck_rise/fall     single-cycle pulses on synchronized sck edges
//   cs_rise/fall      single-cycle pulses on synchronized cs edges
// All flops reset to 0, so a cs held low across reset never produces a
// falling edge; the master has to raise cs and lower it again.
module spi_pin_sync (
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic cs,
   input  logic mosi,
   output logic cs_s,
   output logic mosi_s,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_rise,
   output logic cs_fall
);

   // bit order {sck, cs, mosi}
   logic [2:0] meta_q, meta_d;
   logic [2:0] sync_q, sync_d;
   logic [2:0] prev_q, prev_d;

   always_comb begin
      meta_d = {sck, cs, mosi};
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign cs_s     = sync_q[1];
   assign mosi_s   = sync_q[0];
   assign sck_rise =  sync_q[2] & ~prev_q[2];
   assign sck_fall = ~sync_q[2] &  prev_q[2];
   assign cs_rise  =  sync_q[1] & ~prev_q[1];
   assign cs_fall  = ~sync_q[1] &  prev_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI-NOR flash responder (mode 0, single-bit I/O) backed by an internal byte
// array. Answers READ, PAGE PROGRAM, WREN, WRDI and RDSR.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   sck, cs, mosi  SPI pins from the master (oversampled on clk)
//   miso           serial data out, updated on sck fall
//   wel, wip       write-enable latch, write in progress
//   state_out      current FSM state for debug
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | cs high or waiting for cs fall
// OPCODE    | shifting in the 8-bit opcode
// ADDR      | shifting in the 24-bit address (low ADDR_BITS kept)
// READ      | streaming bytes out of the array, address auto-increments
// PROG      | AND-ing received bytes into the array, page-wrapped
// RDSR      | streaming {6'b0, wel, wip} repeatedly
// IGNORE    | discarding everything until cs rises
module spi_flash_responder
   import flash_cmd_pkg::*;
#(
   parameter int ADDR_BITS   = 10,
   parameter int PAGE_BITS   = 8,
   parameter int PROG_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   output logic       wel,
   output logic       wip,
   output logic [3:0] state_out
);

   localparam int CNT_W = $clog2(PROG_CYCLES + 1);
   localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'((1 << PAGE_BITS) - 1);

   logic cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;

   spi_pin_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .sck      (sck),
      .cs       (cs),
      .mosi     (mosi),
      .cs_s     (cs_s),
      .mosi_s   (mosi_s),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .cs_rise  (cs_rise),
      .cs_fall  (cs_fall)
   );

   state_e               state_q, state_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic [2:0]           out_cnt_q, out_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]     wip_cnt_q, wip_cnt_d;
   logic                 miso_q, miso_d;
   logic                 wel_q, wel_d;
   logic                 wip_q, wip_d;
   logic                 is_prog_q, is_prog_d;
   logic                 wren_pend_q, wren_pend_d;
   logic                 wrdi_pend_q, wrdi_pend_d;
   logic                 extra_q, extra_d;
   logic                 prog_done_q, prog_done_d;
   logic                 rmw_pend_q, rmw_pend_d;

   // Array is stored inverted so that an all-zero power-up reads as erased 0xFF.
   logic [7:0] mem_inv [2**ADDR_BITS];
   logic [7:0] rd_data_q;
   logic       mem_we;
   logic [7:0] mem_wdata;

   logic [7:0]           rx_byte;
   logic [ADDR_BITS-1:0] rx_addr;
   logic [7:0]           status;

   assign rx_byte = {shift_q[6:0], mosi_s};
   assign rx_addr = {addr_q[ADDR_BITS-2:0], mosi_s};
   assign status  = {6'b0, wel_q, wip_q};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      out_cnt_d   = out_cnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      wip_cnt_d   = wip_cnt_q;
      miso_d      = miso_q;
      wel_d       = wel_q;
      wip_d       = wip_q;
      is_prog_d   = is_prog_q;
      wren_pend_d = wren_pend_q;
      wrdi_pend_d = wrdi_pend_q;
      extra_d     = extra_q;
      prog_done_d = prog_done_q;
      rmw_pend_d  = rmw_pend_q;
      mem_we      = 1'b0;
      mem_wdata   = rd_data_q & shift_q;

      if (wip_q) begin
         wip_cnt_d = wip_cnt_q - CNT_W'(1);
         if (wip_cnt_q == CNT_W'(1)) wip_d = 1'b0;
      end

      // Second half of the program RMW: rd_data_q holds array[addr] by now.
      if (rmw_pend_q && !rst) begin
         mem_we      = 1'b1;
         rmw_pend_d  = 1'b0;
         prog_done_d = 1'b1;
         addr_d      = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_BITS'(1)) & PAGE_MASK);
      end

      if (cs_s) begin
         state_d     = ST_IDLE;
         bit_cnt_d   = '0;
         out_cnt_d   = '0;
         miso_d      = 1'b0;
         is_prog_d   = 1'b0;
         wren_pend_d = 1'b0;
         wrdi_pend_d = 1'b0;
         extra_d     = 1'b0;
         prog_done_d = 1'b0;
         if (cs_rise) begin
            if (wren_pend_q && !extra_q) wel_d = 1'b1;
            if (wrdi_pend_q && !extra_q) wel_d = 1'b0;
            // a byte still mid-RMW counts as written
            if (prog_done_q || rmw_pend_q) begin
               wel_d     = 1'b0;
               wip_d     = 1'b1;
               wip_cnt_d = CNT_W'(PROG_CYCLES);
            end
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d   = ST_OPCODE;
                  bit_cnt_d = '0;
               end
            end
            ST_OPCODE: begin
               if (sck_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     out_cnt_d = '0;
                     state_d   = ST_IGNORE;
                     if (rx_byte == OP_RDSR) begin
                        state_d = ST_RDSR;
                     end else if (!wip_q) begin
                        case (rx_byte)
                           OP_READ: begin
                              state_d   = ST_ADDR;
                              is_prog_d = 1'b0;
                           end
                           OP_PP: begin
                              if (wel_q) begin
                                 state_d   = ST_ADDR;
                                 is_prog_d = 1'b1;
                              end
                           end
                           OP_WREN: wren_pend_d = 1'b1;
                           OP_WRDI: wrdi_pend_d = 1'b1;
                           default: ;
                        endcase
                     end
                  end
               end
            end
            ST_ADDR: begin
               if (sck_rise) begin
                  addr_d    = rx_addr;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = '0;
                     out_cnt_d = '0;
                     state_d   = is_prog_q ? ST_PROG : ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (sck_fall) begin
                  miso_d    = rd_data_q[~out_cnt_q];
                  out_cnt_d = out_cnt_q + 3'd1;
                  if (out_cnt_q == 3'd7) addr_d = addr_q + ADDR_BITS'(1);
               end
            end
            ST_PROG: begin
               if (sck_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d  = '0;
                     rmw_pend_d = 1'b1;
                  end
               end
            end
            ST_RDSR: begin
               if (sck_fall) begin
                  miso_d    = status[~out_cnt_q];
                  out_cnt_d = out_cnt_q + 3'd1;
               end
            end
            ST_IGNORE: begin
               miso_d = 1'b0;
               if (sck_rise) extra_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         out_cnt_q   <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         wip_cnt_q   <= '0;
         miso_q      <= 1'b0;
         wel_q       <= 1'b0;
         wip_q       <= 1'b0;
         is_prog_q   <= 1'b0;
         wren_pend_q <= 1'b0;
         wrdi_pend_q <= 1'b0;
         extra_q     <= 1'b0;
         prog_done_q <= 1'b0;
         rmw_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         out_cnt_q   <= out_cnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         wip_cnt_q   <= wip_cnt_d;
         miso_q      <= miso_d;
         wel_q       <= wel_d;
         wip_q       <= wip_d;
         is_prog_q   <= is_prog_d;
         wren_pend_q <= wren_pend_d;
         wrdi_pend_q <= wrdi_pend_d;
         extra_q     <= extra_d;
         prog_done_q <= prog_done_d;
         rmw_pend_q  <= rmw_pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_inv[addr_q] <= ~mem_wdata;
      rd_data_q <= ~mem_inv[addr_q];
   end

   assign miso      = miso_q;
   assign wel       = wel_q;
   assign wip       = wip_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
   import flash_cmd_pkg::*;

   localparam int TB_PROG = 300;
   localparam int HALF    = 5;

   logic       clk = 1'b0;
   logic       rst, sck, cs, mosi;
   logic       miso, wel, wip;
   logic [3:0] state_out;

   int checks   = 0;
   int failures = 0;
   int wip_run  = 0;
   int wip_last = 0;

   always #5 clk = ~clk;

   spi_flash_responder #(
      .ADDR_BITS   (10),
      .PAGE_BITS   (8),
      .PROG_CYCLES (TB_PROG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sck       (sck),
      .cs        (cs),
      .mosi      (mosi),
      .miso      (miso),
      .wel       (wel),
      .wip       (wip),
      .state_out (state_out)
   );

   // length of the most recent completed wip pulse, in clk cycles
   always @(negedge clk) begin
      if (wip) wip_run = wip_run + 1;
      else begin
         if (wip_run != 0) wip_last = wip_run;
         wip_run = 0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         tick(HALF);
         sck   = 1'b1;
         rx[i] = miso;
         tick(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic cs_begin();
      cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_end();
      tick(HALF);
      cs = 1'b1;
      tick(8);
   endtask

   task automatic send_cmd_addr(input logic [7:0] op, input logic [23:0] a);
      logic [7:0] d;
      xfer(op, d);
      xfer(a[23:16], d);
      xfer(a[15:8], d);
      xfer(a[7:0], d);
   endtask

   task automatic simple_cmd(input logic [7:0] op);
      logic [7:0] d;
      cs_begin();
      xfer(op, d);
      cs_end();
   endtask

   task automatic rdsr_chk(input string tag, input logic [7:0] exp);
      logic [7:0] d;
      cs_begin();
      xfer(OP_RDSR, d);
      xfer(8'h00, d);
      cs_end();
      check_eq(tag, d, exp);
   endtask

   // exps holds up to four expected bytes, first byte in [31:24]
   task automatic read_chk(input string tag, input logic [23:0] a, input int n, input logic [31:0] exps);
      logic [7:0] d;
      cs_begin();
      send_cmd_addr(OP_READ, a);
      for (int k = 0; k < n; k++) begin
         xfer(8'h00, d);
         check_eq($sformatf("%s[%0d]", tag, k), d, exps[31-8*k -: 8]);
      end
      cs_end();
   endtask

   // data holds up to three bytes, first byte in [23:16]
   task automatic pp(input logic [23:0] a, input logic [23:0] data, input int n);
      logic [7:0] d;
      cs_begin();
      send_cmd_addr(OP_PP, a);
      for (int k = 0; k < n; k++) xfer(data[23-8*k -: 8], d);
      cs_end();
   endtask

   task automatic wait_wip_clear(input string tag);
      for (int i = 0; i < 2000 && wip === 1'b1; i++) tick(1);
      check_eq(tag, wip, 1'b0);
      tick(3);
   endtask

   initial begin
      logic [7:0] d;
      rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0;
      tick(5);
      rst = 1'b0;
      tick(4);

      check_eq("rst_miso", miso, 1'b0);
      check_eq("rst_wel", wel, 1'b0);
      check_eq("rst_wip", wip, 1'b0);
      check_eq("rst_state", state_out, ST_IDLE);

      rdsr_chk("rdsr_reset", 8'h00);
      read_chk("rd_fresh", 24'h000010, 3, 32'hFFFF_FF00);

      pp(24'h000010, 24'hA5_0000, 1);
      check_eq("pp_nowren_wel", wel, 1'b0);
      check_eq("pp_nowren_wip", wip, 1'b0);
      read_chk("rd_after_nowren", 24'h000010, 1, 32'hFF00_0000);

      simple_cmd(OP_WREN);
      check_eq("wren_wel", wel, 1'b1);
      pp(24'h0000FE, 24'h11_22_33, 3);
      check_eq("pp_commit_wel", wel, 1'b0);
      check_eq("pp_commit_wip", wip, 1'b1);
      rdsr_chk("rdsr_busy", 8'h01);
      wait_wip_clear("wip_clear1");
      check_eq("wip_len", wip_last, TB_PROG);
      read_chk("rd_page_lo", 24'h0000FE, 2, 32'h1122_0000);
      read_chk("rd_page_wrap", 24'h000000, 1, 32'h3300_0000);
      read_chk("rd_next_page", 24'h000100, 1, 32'hFF00_0000);

      simple_cmd(OP_WREN);
      pp(24'h000020, 24'h3C_0000, 1);
      wait_wip_clear("wip_clear2");
      simple_cmd(OP_WREN);
      pp(24'h000020, 24'hF0_0000, 1);
      wait_wip_clear("wip_clear3");
      check_eq("wip_len2", wip_last, TB_PROG);
      read_chk("rd_and", 24'h000020, 1, 32'h3000_0000);

      simple_cmd(OP_WREN);
      pp(24'h0003FF, 24'h5A_0000, 1);
      wait_wip_clear("wip_clear4");
      read_chk("rd_arr_wrap", 24'h0003FF, 2, 32'h5A33_0000);
      read_chk("rd_alias", 24'h4003FF, 1, 32'h5A00_0000);

      simple_cmd(OP_WREN);
      check_eq("wren2_wel", wel, 1'b1);
      simple_cmd(OP_WRDI);
      check_eq("wrdi_wel", wel, 1'b0);

      // WREN followed by a stray ninth bit must not set the latch
      cs_begin();
      xfer(OP_WREN, d);
      mosi = 1'b0;
      tick(HALF); sck = 1'b1; tick(HALF); sck = 1'b0;
      cs_end();
      check_eq("wren9_wel", wel, 1'b0);

      // reset in the middle of a read with cs held low
      cs_begin();
      send_cmd_addr(OP_READ, 24'h000000);
      xfer(8'h00, d);
      check_eq("mid_rd_byte", d, 8'h33);
      check_eq("mid_rd_state", state_out, ST_READ);
      tick(2);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(3);
      check_eq("rstmid_miso", miso, 1'b0);
      check_eq("rstmid_state", state_out, ST_IDLE);
      xfer(8'h00, d);
      check_eq("rstmid_rx", d, 8'h00);
      check_eq("rstmid_state2", state_out, ST_IDLE);
      cs_end();
      rdsr_chk("rdsr_after_rst", 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
